// File: rtl/pcie_write_queue.sv
// Tags core write messages with their thread ID and queues them for the PCIe RAM writer.
// Latency: a push is at the head the next cycle; wr_enable is combinational from the head.
// Backpressure: req_ready drops when full; issue waits for wr_ready and the post-issue holdoff cycle.
module pcie_write_queue #(
    parameter int DEPTH   = 4,
    parameter int NTHREAD = 8,
    parameter int TID_W   = 3,
    parameter int TID_LSB = 102
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    input  logic [TID_W-1:0]         req_thread,
    input  logic [127:0]             req_data,
    output logic                     req_ready,
    output logic [127:0]             wr_data,
    output logic                     wr_enable,
    input  logic                     wr_ready,
    output logic [NTHREAD-1:0]       thread_pending,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(DEPTH);

    logic [127:0]       mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [OCC_W-1:0]   occ_q;
    logic [OCC_W-1:0]   occ_d;
    logic               holdoff_q;
    logic               overflow_q;

    logic               push;
    logic               pop;
    logic [127:0]       push_dat;
    logic [127:0]       head_dat;
    logic [TID_W-1:0]   head_tid;

    // Ready and issue decisions come from registered state only, so a push
    // can never be issued in the cycle it arrives.
    assign req_ready = (occ_q < DEPTH_OCC);
    assign push      = req_valid & req_ready;
    assign pop       = (occ_q != '0) & wr_ready & ~holdoff_q;
    assign wr_enable = pop;
    assign head_dat  = mem_q[rd_ptr_q];
    assign head_tid  = head_dat[TID_LSB +: TID_W];
    assign wr_data   = pop ? head_dat : '0;
    assign occupancy = occ_q;
    assign overflow  = overflow_q;

    // Stored entry: payload with the thread ID spliced in; bit 127 left for the writer.
    always_comb begin
        push_dat                      = req_data;
        push_dat[TID_LSB +: TID_W]    = req_thread;
    end

    // Entry count: simultaneous push and pop leave it unchanged.
    always_comb begin
        occ_d = occ_q;
        if (push && !pop) begin
            occ_d = occ_q + 1'b1;
        end else if (pop && !push) begin
            occ_d = occ_q - 1'b1;
        end
    end

    // Pointers, occupancy, holdoff after each issue, and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            holdoff_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            occ_q     <= occ_d;
            // Writer ready lags enable by one cycle, so never pulse twice in a row.
            holdoff_q <= pop;
            if (req_valid && !req_ready) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Entry storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

    // Per-thread entry counters drive the pending flags.
    for (genvar t = 0; t < NTHREAD; t++) begin : g_thr
        logic [OCC_W-1:0] cnt_q;
        logic             inc;
        logic             dec;

        assign inc = push && (req_thread == TID_W'(t));
        assign dec = pop && (head_tid == TID_W'(t));

        // Count this thread's entries; push and pop together cancel out.
        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
            end else if (inc && !dec) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (dec && !inc) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end

        assign thread_pending[t] = (cnt_q != '0);
    end

endmodule

// File: tb/tb_pcie_write_queue.sv
// Directed vector table for the queue's corner cases, then randomized traffic
// compared cycle by cycle against a queue-based reference model.
module tb_pcie_write_queue;

    localparam int DEPTH   = 4;
    localparam int NTHREAD = 8;
    localparam int TID_W   = 3;
    localparam int TID_LSB = 102;

    logic               clk = 1'b0;
    logic               rst;
    logic               req_valid;
    logic [TID_W-1:0]   req_thread;
    logic [127:0]       req_data;
    logic               req_ready;
    logic [127:0]       wr_data;
    logic               wr_enable;
    logic               wr_ready;
    logic [NTHREAD-1:0] thread_pending;
    logic [2:0]         occupancy;
    logic               overflow;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pcie_write_queue #(
        .DEPTH(DEPTH), .NTHREAD(NTHREAD), .TID_W(TID_W), .TID_LSB(TID_LSB)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_thread(req_thread), .req_data(req_data),
        .req_ready(req_ready),
        .wr_data(wr_data), .wr_enable(wr_enable), .wr_ready(wr_ready),
        .thread_pending(thread_pending), .occupancy(occupancy), .overflow(overflow)
    );

    typedef struct {
        logic         rst;
        logic         vld;
        logic [2:0]   thr;
        logic [127:0] dat;
        logic         wrr;
        logic         chk;
        logic         e_rdy;
        logic         e_en;
        logic [127:0] e_dat;
        logic [2:0]   e_occ;
        logic [7:0]   e_pend;
        logic         e_ovf;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [127:0] tag(input logic [127:0] d, input int t);
        logic [127:0] r;
        r = d;
        r[TID_LSB +: TID_W] = TID_W'(t);
        return r;
    endfunction

    function automatic logic [127:0] dd(input int n);
        logic [7:0] b;
        b = 8'(8'h10 + n);
        return {16{b}};
    endfunction

    function automatic void row(input logic r, input logic v, input int t, input logic [127:0] d,
                                input logic w, input logic c, input logic rdy, input logic en,
                                input logic [127:0] edat, input int occ, input logic [7:0] pend,
                                input logic ovf);
        vec_t x;
        x.rst = r; x.vld = v; x.thr = 3'(t); x.dat = d; x.wrr = w; x.chk = c;
        x.e_rdy = rdy; x.e_en = en; x.e_dat = edat; x.e_occ = 3'(occ);
        x.e_pend = pend; x.e_ovf = ovf;
        tbl.push_back(x);
    endfunction

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string ctx, input logic rdy, input logic en,
                             input logic [127:0] edat, input logic [2:0] occ,
                             input logic [7:0] pend, input logic ovf);
        check({ctx, " req_ready"},      128'(req_ready),      128'(rdy));
        check({ctx, " wr_enable"},      128'(wr_enable),      128'(en));
        check({ctx, " wr_data"},        wr_data,              edat);
        check({ctx, " occupancy"},      128'(occupancy),      128'(occ));
        check({ctx, " thread_pending"}, 128'(thread_pending), 128'(pend));
        check({ctx, " overflow"},       128'(overflow),       128'(ovf));
    endtask

    // Reference model state
    logic [127:0] mq[$];
    logic         m_hold;
    logic         m_ovf;

    initial begin
        logic [127:0] a5;
        a5 = {16{8'hA5}};

        rst = 1'b1; req_valid = 1'b0; req_thread = '0; req_data = '0; wr_ready = 1'b0;

        // Single push of thread 5, issue, drain
        row(1,0,0,0,0, 0, 0,0,0,0,8'h00,0);
        row(0,1,5,a5,1, 1, 1,0,0,0,8'h00,0);
        row(0,0,0,0,1, 1, 1,1,tag(a5,5),1,8'h20,0);
        row(0,0,0,0,1, 1, 1,0,0,0,8'h00,0);
        row(0,0,0,0,1, 1, 1,0,0,0,8'h00,0);
        // Four threads back to back with writer ready: alternate-cycle pulses, in order
        row(0,1,0,dd(0),1, 1, 1,0,0,0,8'h00,0);
        row(0,1,1,dd(1),1, 1, 1,1,tag(dd(0),0),1,8'h01,0);
        row(0,1,2,dd(2),1, 1, 1,0,0,1,8'h02,0);
        row(0,1,3,dd(3),1, 1, 1,1,tag(dd(1),1),2,8'h06,0);
        row(0,0,0,0,1, 1, 1,0,0,2,8'h0C,0);
        row(0,0,0,0,1, 1, 1,1,tag(dd(2),2),2,8'h0C,0);
        row(0,0,0,0,1, 1, 1,0,0,1,8'h08,0);
        row(0,0,0,0,1, 1, 1,1,tag(dd(3),3),1,8'h08,0);
        row(0,0,0,0,1, 1, 1,0,0,0,8'h00,0);
        // Fill with writer busy, then a fifth request overflows
        row(0,1,4,dd(4),0, 1, 1,0,0,0,8'h00,0);
        row(0,1,5,dd(5),0, 1, 1,0,0,1,8'h10,0);
        row(0,1,6,dd(6),0, 1, 1,0,0,2,8'h30,0);
        row(0,1,7,dd(7),0, 1, 1,0,0,3,8'h70,0);
        row(0,1,0,dd(8),0, 1, 0,0,0,4,8'hF0,0);
        // One-cycle writer ready while full: pop, ready next cycle, held request lands
        row(0,1,0,dd(8),1, 1, 0,1,tag(dd(4),4),4,8'hF0,1);
        row(0,1,0,dd(8),0, 1, 1,0,0,3,8'hE0,1);
        row(0,0,0,0,0, 1, 0,0,0,4,8'hE1,1);
        // Drain
        row(0,0,0,0,1, 1, 0,1,tag(dd(5),5),4,8'hE1,1);
        row(0,0,0,0,1, 1, 1,0,0,3,8'hC1,1);
        row(0,0,0,0,1, 1, 1,1,tag(dd(6),6),3,8'hC1,1);
        row(0,0,0,0,1, 1, 1,0,0,2,8'h81,1);
        row(0,0,0,0,1, 1, 1,1,tag(dd(7),7),2,8'h81,1);
        row(0,0,0,0,1, 1, 1,0,0,1,8'h01,1);
        row(0,0,0,0,1, 1, 1,1,tag(dd(8),0),1,8'h01,1);
        // Same-thread push and pop at occupancy 1
        row(0,1,2,dd(9),0, 1, 1,0,0,0,8'h00,1);
        row(0,1,2,dd(10),1, 1, 1,1,tag(dd(9),2),1,8'h04,1);
        row(0,0,0,0,0, 1, 1,0,0,1,8'h04,1);
        // Build occupancy 3 with holdoff set, then reset
        row(0,1,1,dd(11),1, 1, 1,1,tag(dd(10),2),1,8'h04,1);
        row(0,1,3,dd(12),0, 1, 1,0,0,1,8'h02,1);
        row(0,1,4,dd(13),0, 1, 1,0,0,2,8'h0A,1);
        row(0,1,5,dd(14),1, 1, 1,1,tag(dd(11),1),3,8'h1A,1);
        row(1,1,6,dd(15),1, 1, 1,0,0,3,8'h38,1);
        row(0,0,0,0,1, 1, 1,0,0,0,8'h00,0);
        row(0,1,7,dd(16),1, 1, 1,0,0,0,8'h00,0);
        row(0,0,0,0,1, 1, 1,1,tag(dd(16),7),1,8'h80,0);
        row(0,0,0,0,1, 1, 1,0,0,0,8'h00,0);

        @(posedge clk); #1;
        foreach (tbl[i]) begin
            rst        = tbl[i].rst;
            req_valid  = tbl[i].vld;
            req_thread = tbl[i].thr;
            req_data   = tbl[i].dat;
            wr_ready   = tbl[i].wrr;
            @(negedge clk);
            if (tbl[i].chk) begin
                check_all($sformatf("vec%0d", i), tbl[i].e_rdy, tbl[i].e_en, tbl[i].e_dat,
                          tbl[i].e_occ, tbl[i].e_pend, tbl[i].e_ovf);
            end
            @(posedge clk); #1;
        end

        // Randomized traffic against the reference model
        mq.delete(); m_hold = 1'b0; m_ovf = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            int           bias;
            logic         e_rdy;
            logic         e_en;
            logic [127:0] e_dat;
            logic [7:0]   e_pend;
            bias       = (i / 256) % 4;
            rst        = (i == 0) || ($urandom_range(0, 199) == 0);
            req_valid  = ($urandom_range(0, 3) < 3 - (bias % 2));
            req_thread = 3'($urandom_range(0, NTHREAD - 1));
            req_data   = {$urandom, $urandom, $urandom, $urandom};
            wr_ready   = ($urandom_range(0, 3) < bias + 1);
            @(negedge clk);

            e_rdy  = (mq.size() < DEPTH);
            e_en   = (mq.size() > 0) && wr_ready && !m_hold;
            e_dat  = e_en ? mq[0] : '0;
            e_pend = '0;
            foreach (mq[k]) e_pend[mq[k][TID_LSB +: TID_W]] = 1'b1;
            if (i != 0) begin
                check_all($sformatf("rnd%0d", i), e_rdy, e_en, e_dat, 3'(mq.size()), e_pend, m_ovf);
            end

            if (rst) begin
                mq.delete(); m_hold = 1'b0; m_ovf = 1'b0;
            end else begin
                if (req_valid && !e_rdy) m_ovf = 1'b1;
                if (e_en) void'(mq.pop_front());
                if (req_valid && e_rdy) mq.push_back(tag(req_data, int'(req_thread)));
                m_hold = e_en;
            end
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
